// File: rtl/sid_pkg.sv
// ---------------------------------------------------------------------------
// sid_pkg -- shared definitions for the SID filter register slice.
//   * register address constants for the filter block (0x15..0x18) and the
//     read-only sources (0x19..0x1C)
//   * frame FSM state enum
//   * default bus-decay period
// ---------------------------------------------------------------------------
package sid_pkg;

    localparam logic [4:0] ADDR_FC_LO    = 5'h15;
    localparam logic [4:0] ADDR_FC_HI    = 5'h16;
    localparam logic [4:0] ADDR_RES_FILT = 5'h17;
    localparam logic [4:0] ADDR_MODE_VOL = 5'h18;
    localparam logic [4:0] ADDR_POT_X    = 5'h19;
    localparam logic [4:0] ADDR_POT_Y    = 5'h1A;
    localparam logic [4:0] ADDR_OSC3     = 5'h1B;
    localparam logic [4:0] ADDR_ENV3     = 5'h1C;

    localparam int DECAY_CYCLES_DEFAULT = 8192;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_STROBE = 2'd2
    } sid_state_e;

    // True for the four read-only source registers.
    function automatic logic is_readable(input logic [4:0] a);
        return (a >= ADDR_POT_X) && (a <= ADDR_ENV3);
    endfunction

endpackage

// File: rtl/sid_bus_decay.sv
// ---------------------------------------------------------------------------
// sid_bus_decay -- models the floating data bus of the SID: the last value
// seen on the bus is held, and fades to 0x00 after DECAY_CYCLES ticks with
// no refreshing access.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   tick       ce_1m tick (advances the decay counter)
//   load       bus access that refreshes the latch
//   load_val   value driven on the bus by that access
//   latch_out  current held bus value
// ---------------------------------------------------------------------------
module sid_bus_decay
    import sid_pkg::*;
#(
    parameter int DECAY_CYCLES = DECAY_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] latch_out
);

    localparam int CW = $clog2(DECAY_CYCLES + 1);

    logic [CW-1:0] cnt_reg;
    logic [7:0]    latch_reg;

    // The counter stops at DECAY_CYCLES so a long idle stretch cannot wrap
    // around and revive nothing; the latch clears on the tick that reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            latch_reg <= 8'h00;
        end else if (load) begin
            cnt_reg   <= '0;
            latch_reg <= load_val;
        end else if (tick && (cnt_reg != CW'(DECAY_CYCLES))) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(DECAY_CYCLES - 1))
                latch_reg <= 8'h00;
        end
    end

    assign latch_out = latch_reg;

endmodule

// File: rtl/sid_filter_regs.sv
// ---------------------------------------------------------------------------
// sid_filter_regs -- SID filter register block with frame-synchronous commit.
// CPU writes land in shadow registers; the live outputs load all shadows at
// once in the COMMIT state of each filter frame so a frame never mixes old
// and new settings. A one-clk sample_valid follows in STROBE.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ce_1m                       CPU-rate clock enable
//   cs, we, addr, data_in       CPU bus (sampled only on ce_1m)
//   data_out                    registered read data
//   pot_x, pot_y, osc3, env3    read-only sources (0x19..0x1C)
//   Fc_lo, Fc_hi, Res_Filt, Mode_Vol  committed filter registers
//   sample_valid                start-of-frame strobe
// Build option: SID_BUS_DECAY_EN adds the fading bus latch; without it,
// reads of non-readable addresses return 0x00.
// ---------------------------------------------------------------------------
module sid_filter_regs
    import sid_pkg::*;
#(
    parameter int SAMPLE_DIV   = 1,
    parameter int DECAY_CYCLES = DECAY_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_1m,
    input  logic       cs,
    input  logic       we,
    input  logic [4:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [7:0] pot_x,
    input  logic [7:0] pot_y,
    input  logic [7:0] osc3,
    input  logic [7:0] env3,
    output logic [7:0] Fc_lo,
    output logic [7:0] Fc_hi,
    output logic [7:0] Res_Filt,
    output logic [7:0] Mode_Vol,
    output logic       sample_valid
);

    logic       wr_stb;
    logic       rd_stb;
    logic [7:0] read_src;
    logic [7:0] read_val;
    logic [7:0] decay_q;
    logic       terminal;

    logic [7:0]      div_cnt_reg;
    sid_state_e      state_reg, state_next;
    logic [7:0]      data_out_reg;
    logic [3:0][7:0] live_vec;

    assign wr_stb = ce_1m & cs & we;
    assign rd_stb = ce_1m & cs & ~we;

    // ---- sample divider: counts down, terminal on the tick that sees 1 ----
    assign terminal = ce_1m && (div_cnt_reg == 8'd1);

    always_ff @(posedge clk) begin
        if (rst)
            div_cnt_reg <= 8'(SAMPLE_DIV);
        else if (ce_1m)
            div_cnt_reg <= (div_cnt_reg == 8'd1) ? 8'(SAMPLE_DIV) : div_cnt_reg - 8'd1;
    end

    // ---- frame FSM ----
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (terminal) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_STROBE;
            ST_STROBE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    assign sample_valid = (state_reg == ST_STROBE);

    // ---- shadow and live registers, one slice per filter register ----
    // A write on the terminal tick lands in the shadow on the same edge the
    // FSM enters COMMIT, so the following commit already sees it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            localparam logic [4:0] REG_ADDR  = 5'(ADDR_FC_LO + gi);
            localparam logic [7:0] KEEP_MASK = (gi == 0) ? 8'h07 : 8'hFF;

            logic [7:0] shadow_reg;
            logic [7:0] live_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= 8'h00;
                    live_reg   <= 8'h00;
                end else begin
                    if (wr_stb && (addr == REG_ADDR))
                        shadow_reg <= data_in & KEEP_MASK;
                    if (state_reg == ST_COMMIT)
                        live_reg <= shadow_reg;
                end
            end

            assign live_vec[gi] = live_reg;
        end
    endgenerate

    assign Fc_lo    = live_vec[0];
    assign Fc_hi    = live_vec[1];
    assign Res_Filt = live_vec[2];
    assign Mode_Vol = live_vec[3];

    // ---- read path ----
    always_comb begin
        read_src = 8'h00;
        case (addr)
            ADDR_POT_X: read_src = pot_x;
            ADDR_POT_Y: read_src = pot_y;
            ADDR_OSC3:  read_src = osc3;
            ADDR_ENV3:  read_src = env3;
            default:    read_src = 8'h00;
        endcase
    end

    assign read_val = is_readable(addr) ? read_src : decay_q;

    always_ff @(posedge clk) begin
        if (rst)
            data_out_reg <= 8'h00;
        else if (rd_stb)
            data_out_reg <= read_val;
    end

    assign data_out = data_out_reg;

    // ---- floating bus latch ----
`ifdef SID_BUS_DECAY_EN
    logic       bus_load;
    logic [7:0] bus_val;

    // Writes drive data_in onto the bus; readable-register reads drive the
    // source value. Reads of anything else leave the bus floating.
    assign bus_load = wr_stb | (rd_stb & is_readable(addr));
    assign bus_val  = wr_stb ? data_in : read_src;

    sid_bus_decay #(
        .DECAY_CYCLES(DECAY_CYCLES)
    ) u_bus_decay (
        .clk      (clk),
        .rst      (rst),
        .tick     (ce_1m),
        .load     (bus_load),
        .load_val (bus_val),
        .latch_out(decay_q)
    );
`else
    assign decay_q = 8'h00;
`endif

endmodule

// File: tb/tb_sid_filter_regs.sv
// ---------------------------------------------------------------------------
// tb_sid_filter_regs -- self-checking bench for sid_filter_regs.
// Builds with or without SID_BUS_DECAY_EN; expectations follow the define.
// ---------------------------------------------------------------------------
module tb_sid_filter_regs;

    localparam int DIV = 4;
    localparam int DEC = 16;
    localparam int GAP = 13;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce_1m = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [4:0] addr = 5'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [7:0] pot_x = 8'h00, pot_y = 8'h00, osc3 = 8'h00, env3 = 8'h00;
    logic [7:0] Fc_lo, Fc_hi, Res_Filt, Mode_Vol;
    logic       sample_valid;

    sid_filter_regs #(
        .SAMPLE_DIV  (DIV),
        .DECAY_CYCLES(DEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_1m       (ce_1m),
        .cs          (cs),
        .we          (we),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .pot_x       (pot_x),
        .pot_y       (pot_y),
        .osc3        (osc3),
        .env3        (env3),
        .Fc_lo       (Fc_lo),
        .Fc_hi       (Fc_hi),
        .Res_Filt    (Res_Filt),
        .Mode_Vol    (Mode_Vol),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SID_BUS_DECAY_EN
    bit decay_en = 1'b1;
`else
    bit decay_en = 1'b0;
`endif

    // ---- reference model state ----
    logic [7:0] m_sh [4];
    logic [7:0] m_live [4];
    logic [7:0] m_dout;
    logic [7:0] m_dec_val;
    int         m_last;
    int         tick_idx;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (tick %0d)", nm, act, exp, tick_idx);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b, expected %0b (tick %0d)", nm, act, exp, tick_idx);
        end
    endtask

    function automatic logic [7:0] dec(input logic [7:0] v);
        return decay_en ? v : 8'h00;
    endfunction

    // Bus value seen by a non-readable read on the current tick.
    function automatic logic [7:0] model_decay();
        if (!decay_en)
            return 8'h00;
        else if (tick_idx - m_last - 1 >= DEC)
            return 8'h00;
        else
            return m_dec_val;
    endfunction

    function automatic logic [7:0] dut_live(input int i);
        case (i)
            0:       return Fc_lo;
            1:       return Fc_hi;
            2:       return Res_Filt;
            default: return Mode_Vol;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]   = 8'h00;
            m_live[i] = 8'h00;
        end
        m_dout    = 8'h00;
        m_dec_val = 8'h00;
        m_last    = -1;
        tick_idx  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ce_1m = 1'b0; cs = 1'b0; we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        $display("reset");
        chk1("rst_sample_valid", sample_valid, 1'b0);
        chk8("rst_data_out", data_out, 8'h00);
        for (int i = 0; i < 4; i++)
            chk8($sformatf("rst_live%0d", i), dut_live(i), 8'h00);
    endtask

    // One ce_1m bus cycle followed by GAP idle clocks, all checked.
    task automatic do_tick(input logic cs_i, input logic we_i,
                           input logic [4:0] a, input logic [7:0] d);
        logic       term;
        logic [7:0] src;
        bit         rdbl;
        int         ai;
        @(negedge clk);
        cs = cs_i; we = we_i; addr = a; data_in = d; ce_1m = 1'b1;
        @(posedge clk);
        #1;
        ce_1m = 1'b0; cs = 1'b0; we = 1'b0;

        ai   = int'(a);
        term = ((tick_idx + 1) % DIV) == 0;
        rdbl = (ai >= 'h19) && (ai <= 'h1C);
        case (ai)
            'h19:    src = pot_x;
            'h1A:    src = pot_y;
            'h1B:    src = osc3;
            'h1C:    src = env3;
            default: src = 8'h00;
        endcase
        if (cs_i && we_i) begin
            if (ai >= 'h15 && ai <= 'h18)
                m_sh[ai - 'h15] = (ai == 'h15) ? (d & 8'h07) : d;
            if (decay_en) begin
                m_dec_val = d;
                m_last    = tick_idx;
            end
        end else if (cs_i) begin
            if (rdbl) begin
                m_dout = src;
                if (decay_en) begin
                    m_dec_val = src;
                    m_last    = tick_idx;
                end
            end else begin
                m_dout = model_decay();
            end
        end
        $display("tick %0d cs=%0b we=%0b addr=0x%02h din=0x%02h term=%0b",
                 tick_idx, cs_i, we_i, a, d, term);
        tick_idx++;

        for (int g = 0; g < GAP; g++) begin
            @(negedge clk);
            if (term && g == 1)
                for (int i = 0; i < 4; i++) m_live[i] = m_sh[i];
            chk1("sample_valid", sample_valid, term && (g == 1));
            chk8("data_out", data_out, m_dout);
            for (int i = 0; i < 4; i++)
                chk8($sformatf("live%0d", i), dut_live(i), m_live[i]);
        end
    endtask

    typedef struct {
        logic       we;
        logic [4:0] a;
        logic [7:0] d;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        model_reset();
        do_reset();

        // ---- table-driven bus vectors ----
        pot_x = 8'h11; pot_y = 8'h22; osc3 = 8'h5A; env3 = 8'h44;
        tbl[0] = '{1'b1, 5'h16, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 5'h00, 8'h00, 1'b1, dec(8'hA5)};
        tbl[2] = '{1'b0, 5'h1B, 8'h00, 1'b1, 8'h5A};
        tbl[3] = '{1'b0, 5'h05, 8'h00, 1'b1, dec(8'h5A)};
        tbl[4] = '{1'b0, 5'h19, 8'h00, 1'b1, 8'h11};
        tbl[5] = '{1'b0, 5'h1A, 8'h00, 1'b1, 8'h22};
        tbl[6] = '{1'b0, 5'h1C, 8'h00, 1'b1, 8'h44};
        tbl[7] = '{1'b1, 5'h1E, 8'h77, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 5'h1F, 8'h00, 1'b1, dec(8'h77)};
        tbl[9] = '{1'b0, 5'h15, 8'h00, 1'b1, dec(8'h77)};
        for (int i = 0; i < 10; i++) begin
            do_tick(1'b1, tbl[i].we, tbl[i].a, tbl[i].d);
            if (tbl[i].chk)
                chk8($sformatf("vec%0d_data_out", i), data_out, tbl[i].exp);
        end

        // ---- Fc_lo masking, committed on the terminal tick ----
        do_reset();
        do_tick(1'b1, 1'b1, 5'h15, 8'hFF);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        chk8("fc_lo_before_commit", Fc_lo, 8'h00);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        chk8("fc_lo_masked", Fc_lo, 8'h07);

        // ---- write on tick 2 of 4 held until the frame commit ----
        do_reset();
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        do_tick(1'b1, 1'b1, 5'h18, 8'h3C);
        chk8("mode_vol_held_t2", Mode_Vol, 8'h00);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        chk8("mode_vol_held_t3", Mode_Vol, 8'h00);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        chk8("mode_vol_commit", Mode_Vol, 8'h3C);

        // ---- write on the terminal tick itself ----
        repeat (3) do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        do_tick(1'b1, 1'b1, 5'h17, 8'h9E);
        chk8("res_filt_same_frame", Res_Filt, 8'h9E);

        // ---- bus decay boundary ----
        do_reset();
        do_tick(1'b1, 1'b1, 5'h16, 8'hA5);
        repeat (DEC - 1) do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        do_tick(1'b1, 1'b0, 5'h00, 8'h00);
        chk8("decay_last_tick", data_out, dec(8'hA5));
        do_tick(1'b1, 1'b0, 5'h00, 8'h00);
        chk8("decay_expired", data_out, 8'h00);

        // ---- reset during COMMIT suppresses the strobe ----
        do_reset();
        do_tick(1'b1, 1'b1, 5'h16, 8'h55);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        chk8("pre_rst_fc_hi", Fc_hi, 8'h55);
        osc3 = 8'h5A;
        do_tick(1'b1, 1'b0, 5'h1B, 8'h00);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        do_tick(1'b0, 1'b0, 5'h00, 8'h00);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = 5'h18; data_in = 8'h3C; ce_1m = 1'b1;
        @(posedge clk);
        #1;
        ce_1m = 1'b0; cs = 1'b0; we = 1'b0;
        rst = 1'b1;
        $display("terminal write 0x18=0x3C with reset in COMMIT");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            chk1("rst_commit_no_strobe", sample_valid, 1'b0);
            chk8("rst_commit_data_out", data_out, 8'h00);
            chk8("rst_commit_fc_hi", Fc_hi, 8'h00);
            chk8("rst_commit_mode_vol", Mode_Vol, 8'h00);
        end

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic       r_cs, r_we;
            logic [4:0] r_a;
            pot_x = 8'($urandom); pot_y = 8'($urandom);
            osc3  = 8'($urandom); env3  = 8'($urandom);
            r_cs  = (i < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 6) == 0);
            r_we  = 1'($urandom);
            r_a   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range('h15, 'h1C)) : 5'($urandom);
            do_tick(r_cs, r_we, r_a, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sid_filter_regs.md
SID_FILTER_REGS -- requirements
Module: sid_filter_regs

Interface
REQ-001 Parameter SAMPLE_DIV, default 1: number of ce_1m ticks per filter sample strobe, range 1..255.
REQ-002 Parameter DECAY_CYCLES, default 8192: number of ce_1m ticks before the bus-decay latch clears.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ce_1m  in  1  CPU-rate clock enable; asserted at least 12 clk apart.
REQ-006 cs, we  in  1 each  chip select and write enable, sampled only on ce_1m.
REQ-007 addr  in  5  register address; data_in  in  8  write data.
REQ-008 data_out  out  8  registered read data.
REQ-009 pot_x, pot_y, osc3, env3  in  8 each  read-only register sources.
REQ-010 Fc_lo, Fc_hi, Res_Filt, Mode_Vol  out  8 each  committed filter registers.
REQ-011 sample_valid  out  1  one-clk strobe marking the start of a filter frame.

Function
REQ-012 A write (ce_1m & cs & we) to 0x15..0x18 SHALL update the matching shadow register; Fc_lo shadow keeps bits [2:0], with bits [7:3] forced to 0.
REQ-013 Writes to other addresses SHALL change no shadow register but SHALL load the decay latch.
REQ-014 A divider SHALL count ce_1m ticks and reach terminal every SAMPLE_DIV ticks, then reload.
REQ-015 FSM: IDLE -> COMMIT on a terminal ce_1m tick; COMMIT -> STROBE; STROBE -> IDLE; each state lasts one clk.
REQ-016 In COMMIT, every live output register SHALL load its shadow, so a write on the terminal tick is included.
REQ-017 In STROBE, sample_valid SHALL be 1; it SHALL be 0 in every other state.
REQ-018 Live outputs SHALL change only in COMMIT, so one filter frame never sees a mix of old and new values.
REQ-019 A read (ce_1m & cs & !we) SHALL register data_out on the next clk:
  - 0x19 -> pot_x, 0x1A -> pot_y, 0x1B -> osc3, 0x1C -> env3;
  - any other address -> decay latch.
REQ-020 Every write, and every read of 0x19..0x1C, SHALL load the decay latch with the bus value and clear the decay counter.
REQ-021 After DECAY_CYCLES ce_1m ticks with no such access, the decay latch SHALL become 0x00.
REQ-022 The decay counter SHALL saturate and not wrap.
REQ-023 data_out SHALL hold its value when no read occurs.
REQ-024 addr bits beyond the SID map SHALL be ignored: addresses 0x1D..0x1F behave as write-only registers.

Reset
REQ-025 On rst, the following SHALL be 0: all shadow and live registers, data_out, the decay latch, the decay counter, and sample_valid.
REQ-026 On rst, the FSM SHALL return to IDLE and the divider SHALL reload to SAMPLE_DIV.
REQ-027 rst asserted during COMMIT or STROBE SHALL suppress the pending strobe.

Configuration
REQ-028 With SID_BUS_DECAY_EN defined, the decay latch and counter SHALL behave per REQ-020..REQ-022.
REQ-029 Without SID_BUS_DECAY_EN, reads of non-readable addresses SHALL return 0x00, and no decay latch or counter SHALL be instantiated.

Structure
REQ-030 Package sid_pkg SHALL hold the register address constants (0x15..0x1C), the FSM state enum, and the DECAY_CYCLES default.
REQ-031 Sub-module sid_bus_decay SHALL contain the decay latch and counter; it is instantiated only under SID_BUS_DECAY_EN.

Verification
REQ-032 Write 0xFF to 0x15, then hit a terminal tick -> Fc_lo = 0x07 after COMMIT; sample_valid pulses one clk later.
REQ-033 SAMPLE_DIV=4, write 0x3C to 0x18 on tick 2 -> Mode_Vol stays 0x00 until the COMMIT following tick 4, then becomes 0x3C.
REQ-034 Write on the same ce_1m tick as terminal -> the new value appears in that same frame's COMMIT.
REQ-035 Write 0xA5 to 0x16, then read 0x00:
  - read immediately -> data_out = 0xA5;
  - read after DECAY_CYCLES ticks -> 0x00;
  - without SID_BUS_DECAY_EN -> 0x00 always.
REQ-036 Read 0x1B with osc3 = 0x5A -> data_out = 0x5A; a following read of 0x05 returns 0x5A.
REQ-037 Assert rst in the COMMIT clk -> no sample_valid, and all outputs return to 0x00.
